keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_PERIOD, default 100000, clock cycles each row is driven.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive identical frames needed to accept a press or release.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port col_in  input  4  keypad columns, active-low, pulled up, asynchronous to clk.
REQ-006 SHALL have port row_out  output  4  keypad row drive, active-low, exactly one row low at a time.
REQ-007 SHALL have port key_code  output  4  accepted key, row*4+col.
REQ-008 SHALL have port key_valid  output  1  accepted key pending, held until acknowledged.
REQ-009 SHALL have port key_ack  input  1  consumer acknowledge, sampled on clk.
REQ-010 SHALL have port key_held  output  1  debounced key currently down.
REQ-011 SHALL have port overrun  output  1  sticky; press accepted while key_valid high.

Function
REQ-012 SHALL pass col_in through a 2-flop synchronizer before any use.
REQ-013 SHALL drive rows 0,1,2,3 cyclically, each for exactly SCAN_PERIOD cycles; frame = 4*SCAN_PERIOD cycles; row r driven means row_out[r]=0, others 1.
REQ-014 SHALL sample synchronized columns on the last cycle of each row period only.
REQ-015 SHALL evaluate a frame in the cycle after row 3 is sampled, concurrent with row 0 of the next frame: NONE (no low column), SINGLE(code) (exactly one low bit across all rows), MULTI (otherwise).
REQ-016 SHALL run debounce FSM with states RELEASED, PRESS_CNT, PRESSED, RELEASE_CNT and a frame counter.
REQ-017 RELEASED: SINGLE(c) -> PRESS_CNT, candidate=c, count=1; else stay.
REQ-018 PRESS_CNT: SINGLE(candidate) increments count; on count==DEBOUNCE_SCANS -> PRESSED and accept candidate; any other result -> RELEASED, count=0.
REQ-019 PRESSED: NONE -> RELEASE_CNT, count=1; SINGLE(candidate) or MULTI -> stay; SINGLE(other) -> stay (no rollover).
REQ-020 RELEASE_CNT: NONE increments count; on count==DEBOUNCE_SCANS -> RELEASED; any non-NONE -> PRESSED.
REQ-021 On accept: key_code=candidate, key_valid=1 next cycle; key_held=1 in PRESSED and RELEASE_CNT only.
REQ-022 key_valid SHALL clear the cycle after key_ack sampled high while key_valid=1; key_ack while key_valid=0 ignored.
REQ-023 Accept while key_valid=1 SHALL overwrite key_code, keep key_valid=1, set overrun; accept and key_ack in same cycle SHALL load new code, keep key_valid=1, not set overrun.
REQ-024 overrun SHALL clear only on reset.
REQ-025 DEBOUNCE_SCANS=1 SHALL accept on the first SINGLE frame; counter width $clog2(DEBOUNCE_SCANS+1); scan counter width $clog2(SCAN_PERIOD).

Reset
REQ-026 On rst: row_out=4'b1110 (row 0), scan counter 0, synchronizer flops 4'b1111, FSM RELEASED, count 0, key_code=0, key_valid=0, key_held=0, overrun=0.
REQ-027 rst mid-frame SHALL discard partial frame samples; scanning restarts at row 0 first cycle after rst deasserts.

Structure
REQ-028 Debounce state enum, frame-result enum, and default SCAN_PERIOD/DEBOUNCE_SCANS constants SHALL live in the shared IO constants package.
REQ-029 Row scanner/sampler SHALL be sub-module keypad_row_scan (row_out, per-frame 16-bit sample, frame_done pulse); debounce and handshake in keypad_scan.

Verification (bench: SCAN_PERIOD=4, DEBOUNCE_SCANS=2)
REQ-030 Hold row2/col1 closed -> key_valid rises after second complete frame, key_code=9, key_held=1; row_out cycles 1110,1101,1011,0111 every 4 cycles.
REQ-031 Key 9 closed alternate frames only -> key_valid never rises, FSM never PRESSED.
REQ-032 Keys 0 and 5 closed together -> frame MULTI, key_valid stays 0.
REQ-033 Accept key 3, no ack, release 2 frames, press key 12 for 2 frames -> key_code=12, key_valid=1, overrun=1; key_ack -> key_valid=0 next cycle, overrun stays 1.
REQ-034 Key 7 pressed then open for 1 frame then closed -> single accept only, key_held stays 1.
REQ-035 Assert rst mid-PRESS_CNT on key 4 -> all outputs reset values, row_out=1110; key 4 re-accepted only after 2 full new frames.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared IO constants for the keypad scanner: default timing,
// debounce state and frame-result enums, frame decode helpers.
package keypad_scan_pkg;

   localparam int unsigned DEF_SCAN_PERIOD    = 100000;
   localparam int unsigned DEF_DEBOUNCE_SCANS = 4;

   typedef enum logic [1:0] {
      ST_RELEASED,
      ST_PRESS_CNT,
      ST_PRESSED,
      ST_RELEASE_CNT
   } deb_state_t;

   typedef enum logic [1:0] {
      FR_NONE,
      FR_SINGLE,
      FR_MULTI
   } frame_res_t;

   // Sample bits are 1 for a closed key, indexed row*4+col.
   function automatic frame_res_t classify(input logic [15:0] s);
      frame_res_t r;
      if (s == 16'h0000)
         r = FR_NONE;
      else if ((s & (s - 16'd1)) == 16'h0000)
         r = FR_SINGLE;
      else
         r = FR_MULTI;
      return r;
   endfunction

   function automatic logic [3:0] encode(input logic [15:0] s);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 16; i++)
         if (s[i])
            c = 4'(i);
      return c;
   endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row driver and column sampler for a 4x4 active-low keypad.
// Ports: clk, rst (async high); i_col_n raw columns; o_row_n row
// drive; o_sample closed-key map (row*4+col); o_frame_done pulse.
module keypad_row_scan
   import keypad_scan_pkg::*;
#(
   parameter int unsigned SCAN_PERIOD = DEF_SCAN_PERIOD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  i_col_n,
   output logic [3:0]  o_row_n,
   output logic [15:0] o_sample,
   output logic        o_frame_done
);

   localparam int CW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(SCAN_PERIOD - 1);

   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_row;
   logic [11:0]   r_acc;
   logic [15:0]   r_sample;
   logic          r_done;
   logic          w_last;
   logic [3:0]    w_closed;

   assign w_last   = (r_cnt == LAST);
   assign w_closed = ~r_sync2;
   assign o_row_n  = ~(4'b0001 << r_row);
   assign o_sample = r_sample;
   assign o_frame_done = r_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1  <= 4'b1111;
         r_sync2  <= 4'b1111;
         r_cnt    <= '0;
         r_row    <= 2'd0;
         r_acc    <= 12'h000;
         r_sample <= 16'h0000;
         r_done   <= 1'b0;
      end else begin
         r_sync1 <= i_col_n;
         r_sync2 <= r_sync1;
         r_done  <= 1'b0;
         if (w_last) begin
            r_cnt <= '0;
            r_row <= r_row + 2'd1;
            // Rows 0..2 accumulate; row 3 publishes the frame.
            unique case (r_row)
               2'd0: r_acc[3:0]  <= w_closed;
               2'd1: r_acc[7:4]  <= w_closed;
               2'd2: r_acc[11:8] <= w_closed;
               2'd3: begin
                  r_sample <= {w_closed, r_acc};
                  r_done   <= 1'b1;
               end
            endcase
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with frame debounce and valid/ack key output.
// Ports: clk, rst, col_in, row_out, key_code, key_valid, key_ack,
// key_held, overrun (sticky: new key accepted before old one acked).
module keypad_scan
   import keypad_scan_pkg::*;
#(
   parameter int unsigned SCAN_PERIOD    = DEF_SCAN_PERIOD,
   parameter int unsigned DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_held,
   output logic       overrun
);

   localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_SCANS);
   localparam logic [DW-1:0] ONE  = DW'(1);

   logic [15:0] w_sample;
   logic        w_done;
   frame_res_t  w_res;
   logic [3:0]  w_code;
   logic        w_same;
   logic [DW-1:0] w_cnt_inc;

   deb_state_t  r_state;
   deb_state_t  w_state_nxt;
   logic [DW-1:0] r_cnt;
   logic [DW-1:0] w_cnt_nxt;
   logic [3:0]  r_cand;
   logic [3:0]  w_cand_nxt;
   logic        w_accept;

   logic [3:0]  r_code;
   logic        r_valid;
   logic        r_over;

   keypad_row_scan #(
      .SCAN_PERIOD(SCAN_PERIOD)
   ) u_scan (
      .clk         (clk),
      .rst         (rst),
      .i_col_n     (col_in),
      .o_row_n     (row_out),
      .o_sample    (w_sample),
      .o_frame_done(w_done)
   );

   assign w_res     = classify(w_sample);
   assign w_code    = encode(w_sample);
   assign w_same    = (w_res == FR_SINGLE) && (w_code == r_cand);
   assign w_cnt_inc = r_cnt + ONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RELEASED;
         r_cnt   <= '0;
         r_cand  <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cand  <= w_cand_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cand_nxt  = r_cand;
      w_accept    = 1'b0;
      if (w_done) begin
         unique case (r_state)
            ST_RELEASED: begin
               if (w_res == FR_SINGLE) begin
                  w_cand_nxt = w_code;
                  // A single-frame debounce accepts immediately.
                  if (DMAX == ONE) begin
                     w_state_nxt = ST_PRESSED;
                     w_cnt_nxt   = '0;
                     w_accept    = 1'b1;
                  end else begin
                     w_state_nxt = ST_PRESS_CNT;
                     w_cnt_nxt   = ONE;
                  end
               end
            end
            ST_PRESS_CNT: begin
               if (w_same) begin
                  if (w_cnt_inc == DMAX) begin
                     w_state_nxt = ST_PRESSED;
                     w_cnt_nxt   = '0;
                     w_accept    = 1'b1;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end else begin
                  w_state_nxt = ST_RELEASED;
                  w_cnt_nxt   = '0;
               end
            end
            ST_PRESSED: begin
               // Other keys while held are ignored: no rollover.
               if (w_res == FR_NONE) begin
                  if (DMAX == ONE) begin
                     w_state_nxt = ST_RELEASED;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_state_nxt = ST_RELEASE_CNT;
                     w_cnt_nxt   = ONE;
                  end
               end
            end
            ST_RELEASE_CNT: begin
               if (w_res == FR_NONE) begin
                  if (w_cnt_inc == DMAX) begin
                     w_state_nxt = ST_RELEASED;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end else begin
                  w_state_nxt = ST_PRESSED;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = ST_RELEASED;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Accept wins over ack; a simultaneous ack consumes the old key.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_code  <= 4'd0;
         r_valid <= 1'b0;
         r_over  <= 1'b0;
      end else if (w_accept) begin
         r_code  <= w_cand_nxt;
         r_valid <= 1'b1;
         if (r_valid && !key_ack)
            r_over <= 1'b1;
      end else if (key_ack && r_valid) begin
         r_valid <= 1'b0;
      end
   end

   assign key_code  = r_code;
   assign key_valid = r_valid;
   assign overrun   = r_over;
   assign key_held  = (r_state == ST_PRESSED) ||
                      (r_state == ST_RELEASE_CNT);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_PERIOD=4, DEBOUNCE_SCANS=2.
// A keypad model pulls columns low for closed keys on driven rows.
module tb_keypad_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_ack = 1'b0;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic        overrun;
   logic [15:0] keys = 16'h0000;
   int          n_cmp = 0;
   int          n_err = 0;

   keypad_scan #(
      .SCAN_PERIOD   (4),
      .DEBOUNCE_SCANS(2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .col_in   (col_in),
      .row_out  (row_out),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_ack  (key_ack),
      .key_held (key_held),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   always_comb begin
      col_in = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !row_out[r])
               col_in[c] = 1'b0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Returns #1 after the edge that enters row 0, cycle 0.
   task automatic goto_frame_start;
      int n;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (row_out !== 4'b0111 && n < 40);
      while (row_out !== 4'b1110 && n < 60) begin
         @(posedge clk); #1; n++;
      end
      n_cmp++;
      if (row_out !== 4'b1110) begin
         n_err++;
         $display("FAIL frame_sync: row_out=%b want 1110", row_out);
      end
   endtask

   // n clean frames since the last key change, with the last committed.
   task automatic frames(input int n);
      repeat (n) goto_frame_start();
      @(posedge clk); #1;
   endtask

   task automatic pulse_ack;
      key_ack = 1'b1;
      @(posedge clk); #1;
      key_ack = 1'b0;
   endtask

   task automatic test_reset;
      rst  = 1'b1;
      keys = 16'h0200;
      @(posedge clk); #1;
      n_cmp++;
      if (row_out !== 4'b1110) begin n_err++;
         $display("FAIL rst_row: got %b want 1110", row_out); end
      n_cmp++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin n_err++;
         $display("FAIL rst_flags: valid=%b held=%b want 0 0",
                  key_valid, key_held); end
      n_cmp++;
      if (key_code !== 4'd0 || overrun !== 1'b0) begin n_err++;
         $display("FAIL rst_code: code=%0d ovr=%b want 0 0",
                  key_code, overrun); end
   endtask

   // Release rst and expect accept of `code` on the 33rd edge.
   task automatic test_first_accept(input logic [3:0] code);
      logic [3:0] exp_row;
      rst = 1'b0;
      for (int i = 1; i <= 33; i++) begin
         @(posedge clk); #1;
         if (i % 4 == 0) begin
            unique case (i % 16)
               0:  exp_row = 4'b1110;
               4:  exp_row = 4'b1101;
               8:  exp_row = 4'b1011;
               default: exp_row = 4'b0111;
            endcase
            n_cmp++;
            if (row_out !== exp_row) begin n_err++;
               $display("FAIL row_cycle@%0d: got %b want %b",
                        i, row_out, exp_row); end
         end
         if (i == 32) begin
            n_cmp++;
            if (key_valid !== 1'b0 || key_held !== 1'b0) begin n_err++;
               $display("FAIL early_accept: valid=%b held=%b want 0 0",
                        key_valid, key_held); end
         end
         if (i == 33) begin
            n_cmp++;
            if (key_valid !== 1'b1 || key_held !== 1'b1) begin n_err++;
               $display("FAIL accept: valid=%b held=%b want 1 1",
                        key_valid, key_held); end
            n_cmp++;
            if (key_code !== code || overrun !== 1'b0) begin n_err++;
               $display("FAIL accept_code: code=%0d ovr=%b want %0d 0",
                        key_code, overrun, code); end
         end
      end
   endtask

   task automatic test_ack_release;
      pulse_ack();
      n_cmp++;
      if (key_valid !== 1'b0 || key_held !== 1'b1) begin n_err++;
         $display("FAIL ack: valid=%b held=%b want 0 1",
                  key_valid, key_held); end
      goto_frame_start();
      keys = 16'h0000;
      frames(1);
      n_cmp++;
      if (key_held !== 1'b1) begin n_err++;
         $display("FAIL release_cnt: held=%b want 1", key_held); end
      frames(1);
      n_cmp++;
      if (key_held !== 1'b0) begin n_err++;
         $display("FAIL released: held=%b want 0", key_held); end
      pulse_ack();
      n_cmp++;
      if (key_valid !== 1'b0) begin n_err++;
         $display("FAIL idle_ack: valid=%b want 0", key_valid); end
   endtask

   task automatic test_alternate;
      for (int i = 0; i < 6; i++) begin
         goto_frame_start();
         keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
         n_cmp++;
         if (key_valid !== 1'b0 || key_held !== 1'b0) begin n_err++;
            $display("FAIL alternate@%0d: valid=%b held=%b want 0 0",
                     i, key_valid, key_held); end
      end
      frames(1);
      n_cmp++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin n_err++;
         $display("FAIL alternate_end: valid=%b held=%b want 0 0",
                  key_valid, key_held); end
   endtask

   task automatic test_multi;
      goto_frame_start();
      keys = 16'h0021;
      frames(3);
      n_cmp++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin n_err++;
         $display("FAIL multi: valid=%b held=%b want 0 0",
                  key_valid, key_held); end
   endtask

   task automatic test_collision;
      goto_frame_start();
      keys = 16'h0040;
      frames(2);
      n_cmp++;
      if (key_valid !== 1'b1 || key_code !== 4'd6) begin n_err++;
         $display("FAIL key6: valid=%b code=%0d want 1 6",
                  key_valid, key_code); end
      goto_frame_start();
      keys = 16'h0000;
      frames(2);
      goto_frame_start();
      keys = 16'h0400;
      goto_frame_start();
      goto_frame_start();
      pulse_ack();
      n_cmp++;
      if (key_valid !== 1'b1 || key_code !== 4'd10) begin n_err++;
         $display("FAIL ack_accept: valid=%b code=%0d want 1 10",
                  key_valid, key_code); end
      n_cmp++;
      if (overrun !== 1'b0) begin n_err++;
         $display("FAIL ack_accept_ovr: got %b want 0", overrun); end
      pulse_ack();
      goto_frame_start();
      keys = 16'h0000;
      frames(2);
   endtask

   task automatic test_overrun;
      goto_frame_start();
      keys = 16'h0008;
      frames(2);
      n_cmp++;
      if (key_valid !== 1'b1 || key_code !== 4'd3) begin n_err++;
         $display("FAIL key3: valid=%b code=%0d want 1 3",
                  key_valid, key_code); end
      goto_frame_start();
      keys = 16'h0000;
      frames(2);
      goto_frame_start();
      keys = 16'h1000;
      frames(2);
      n_cmp++;
      if (key_valid !== 1'b1 || key_code !== 4'd12) begin n_err++;
         $display("FAIL key12: valid=%b code=%0d want 1 12",
                  key_valid, key_code); end
      n_cmp++;
      if (overrun !== 1'b1) begin n_err++;
         $display("FAIL overrun_set: got %b want 1", overrun); end
      pulse_ack();
      n_cmp++;
      if (key_valid !== 1'b0 || overrun !== 1'b1) begin n_err++;
         $display("FAIL overrun_sticky: valid=%b ovr=%b want 0 1",
                  key_valid, overrun); end
      goto_frame_start();
      keys = 16'h0000;
      frames(2);
   endtask

   task automatic test_bounce;
      goto_frame_start();
      keys = 16'h0080;
      frames(2);
      n_cmp++;
      if (key_valid !== 1'b1 || key_code !== 4'd7) begin n_err++;
         $display("FAIL key7: valid=%b code=%0d want 1 7",
                  key_valid, key_code); end
      pulse_ack();
      goto_frame_start();
      keys = 16'h0000;
      goto_frame_start();
      keys = 16'h0080;
      @(posedge clk); #1;
      n_cmp++;
      if (key_held !== 1'b1) begin n_err++;
         $display("FAIL bounce_open: held=%b want 1", key_held); end
      frames(3);
      n_cmp++;
      if (key_held !== 1'b1 || key_valid !== 1'b0) begin n_err++;
         $display("FAIL bounce_reaccept: held=%b valid=%b want 1 0",
                  key_held, key_valid); end
      goto_frame_start();
      keys = 16'h0000;
      frames(2);
   endtask

   task automatic test_reset_mid;
      goto_frame_start();
      keys = 16'h0010;
      frames(1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (row_out !== 4'b1110 || key_held !== 1'b0) begin n_err++;
         $display("FAIL mid_rst_row: row=%b held=%b want 1110 0",
                  row_out, key_held); end
      n_cmp++;
      if (key_valid !== 1'b0 || overrun !== 1'b0 ||
          key_code !== 4'd0) begin n_err++;
         $display("FAIL mid_rst_out: valid=%b ovr=%b code=%0d want 0 0 0",
                  key_valid, overrun, key_code); end
      @(posedge clk); #1;
      test_first_accept(4'd4);
   endtask

   initial begin
      test_reset();
      test_first_accept(4'd9);
      test_ack_release();
      test_alternate();
      test_multi();
      test_collision();
      test_overrun();
      test_bounce();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
